// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
//   Round-robin arbiter with grant hold for sharing one multi-cycle resource
//   between N requesters. A rotating one-hot pointer selects the winner
//   (pointer position first, wrapping upward). The registered grant is held
//   until the owner signals done, drops its request, or the hold limit fires.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no owner, gnt = 0; any request is granted on the next edge
//   GRANT | one owner holds gnt; release on done / abort / hold limit
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   req[N]     in   per-requester request level
//   done       in   current owner finishes this cycle (ignored when idle)
//   gnt[N]     out  registered one-hot grant, zero when idle
//   gnt_id     out  binary index of gnt, zero when idle
//   gnt_valid  out  high when gnt != 0
//   timeout    out  one-cycle pulse after a hold-limit forced release
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  ptr_rot;
    logic          owner_req;
    logic          at_limit;
    logic          release_now;

    // Doubled-vector kill chain: subtracting the one-hot pointer from {req,req}
    // borrows through the zero bits at and above the pointer, so the AND with
    // the inverted difference isolates the first request at/above the pointer,
    // wrapping into the upper copy. Folding both halves gives the one-hot winner.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [N-1:0] p);
        logic [2*N-1:0] dreq;
        logic [2*N-1:0] dgnt;
        dreq = {r, r};
        dgnt = dreq & ~(dreq - {{N{1'b0}}, p});
        return dgnt[N-1:0] | dgnt[2*N-1:N];
    endfunction

    // Pointer after a release: one position above the current owner.
    assign ptr_rot     = {gnt_q[N-2:0], gnt_q[N-1]};
    assign owner_req   = |(req & gnt_q);
    assign at_limit    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
    assign release_now = done | ~owner_req | at_limit;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, ptr_q);
                    hold_d  = HW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = ptr_rot;
                    timeout_d = at_limit & ~done & owner_req;
                    gnt_d     = rr_pick(req, ptr_rot);
                    if (|gnt_d) begin
                        hold_d  = HW'(1);
                        state_d = GRANT;
                    end else begin
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD != 0) begin
                    // No release implies the limit was not reached, so this
                    // increment saturates at MAX_HOLD.
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= {{(N-1){1'b0}}, 1'b1};
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) gnt_id = gnt_id | IDW'(i);
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: two instances (hold limits 16 and 4) share one
// directed stimulus; a behavioural model per instance is checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rr_hold_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       v_a, v_b, to_a, to_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(16)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(v_a), .timeout(to_a));

    rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(v_b), .timeout(to_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_own  [2];
    int         m_ptr  [2];
    int         m_hold [2];
    bit         m_to   [2];
    int         m_wait [2][N];
    logic [3:0] m_prevreq;
    bit         m_live = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  mh;
            bit  started;
            bit  lim;
            mh      = (k == 0) ? 16 : 4;
            started = 0;
            if (rst) begin
                m_own[k]  = -1;
                m_ptr[k]  = 0;
                m_hold[k] = 0;
                m_to[k]   = 0;
            end else if (m_own[k] < 0) begin
                m_to[k] = 0;
                if (req != 0) begin
                    m_own[k]  = pick(req, m_ptr[k]);
                    m_hold[k] = 1;
                    started   = 1;
                end
            end else begin
                lim = (mh != 0) && (m_hold[k] == mh);
                if (done || !req[m_own[k]] || lim) begin
                    m_to[k]  = lim && !done && req[m_own[k]];
                    m_ptr[k] = (m_own[k] + 1) % N;
                    m_own[k] = pick(req, m_ptr[k]);
                    if (m_own[k] >= 0) begin
                        m_hold[k] = 1;
                        started   = 1;
                    end else begin
                        m_hold[k] = 0;
                    end
                end else begin
                    m_to[k] = 0;
                    if (m_hold[k] < mh) m_hold[k]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rst || !req[i] || m_own[k] == i) m_wait[k][i] = 0;
                else if (started) m_wait[k][i]++;
            end
        end
        m_prevreq = req;
        m_live    = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] g, eg;
                logic [1:0] id, eid;
                logic       v, t;
                g  = (k == 0) ? gnt_a : gnt_b;
                id = (k == 0) ? id_a  : id_b;
                v  = (k == 0) ? v_a   : v_b;
                t  = (k == 0) ? to_a  : to_b;
                eg  = (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
                eid = (m_own[k] < 0) ? 2'd0 : 2'(m_own[k]);
                chk($sformatf("model_gnt[%0d]", k), 32'(g), 32'(eg));
                chk($sformatf("model_id[%0d]", k), 32'(id), 32'(eid));
                chk($sformatf("model_valid[%0d]", k), 32'(v), 32'(eg != 0));
                chk($sformatf("model_timeout[%0d]", k), 32'(t), 32'(m_to[k]));
                chk($sformatf("inv_onehot0[%0d]", k), 32'($onehot0(g)), 32'd1);
                chk($sformatf("inv_subset[%0d]", k), 32'(g & ~m_prevreq), 32'd0);
                for (int i = 0; i < N; i++) begin
                    if (m_wait[k][i] > N - 1)
                        chk($sformatf("inv_starve[%0d][%0d]", k, i), 32'(m_wait[k][i]), 32'(N - 1));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic lit_a(input string name, input logic [3:0] eg, input logic et);
        chk({name, "_gnt"}, 32'(gnt_a), 32'(eg));
        chk({name, "_to"},  32'(to_a),  32'(et));
    endtask

    task automatic lit_b(input string name, input logic [3:0] eg, input logic et);
        chk({name, "_gnt"}, 32'(gnt_b), 32'(eg));
        chk({name, "_to"},  32'(to_b),  32'(et));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle
        cyc(4'b1111, 1'b0, 1'b1);
        lit_a("rst0", 4'b0000, 1'b0);
        chk("rst0_valid", 32'(v_a), 32'd0);
        cyc(4'b1111, 1'b0, 1'b1);
        lit_a("rst1", 4'b0000, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        lit_a("first", 4'b0001, 1'b0);
        chk("first_id", 32'(id_a), 32'd0);

        // Round-robin rotation, done every grant cycle
        cyc(4'b1111, 1'b1, 1'b0); lit_a("rot1", 4'b0010, 1'b0);
        chk("rot1_id", 32'(id_a), 32'd1);
        cyc(4'b1111, 1'b1, 1'b0); lit_a("rot2", 4'b0100, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0); lit_a("rot3", 4'b1000, 1'b0);
        chk("rot3_id", 32'(id_a), 32'd3);
        cyc(4'b1111, 1'b1, 1'b0); lit_a("rot4", 4'b0001, 1'b0);

        // Wrap and skip
        cyc(4'b1111, 1'b1, 1'b0); lit_a("ws_a", 4'b0010, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0); lit_a("ws_b", 4'b0100, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0); lit_a("wrap", 4'b0001, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0); lit_a("skip", 4'b0010, 1'b0);

        // Idle behaviour, done ignored while idle
        cyc(4'b0000, 1'b0, 1'b0); lit_a("idle0", 4'b0000, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0); lit_a("idle1", 4'b0000, 1'b0);

        // Hold and abort
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0101, 1'b0, 1'b0); lit_a("hold_g", 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0101, 1'b0, 1'b0);
            lit_a($sformatf("hold%0d", i), 4'b0001, 1'b0);
        end
        cyc(4'b0100, 1'b0, 1'b0); lit_a("abort", 4'b0100, 1'b0);

        // Reset mid-grant
        cyc(4'b0100, 1'b0, 1'b0); lit_a("mid_hold", 4'b0100, 1'b0);
        cyc(4'b0100, 1'b0, 1'b1); lit_a("mid_rst", 4'b0000, 1'b0);
        cyc(4'b0110, 1'b0, 1'b0); lit_a("post_rst", 4'b0010, 1'b0);

        // Timeout on the MAX_HOLD=4 instance
        cyc(4'b0011, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0011, 1'b0, 1'b0);
            lit_b($sformatf("to_hold0_%0d", i), 4'b0001, 1'b0);
        end
        cyc(4'b0011, 1'b0, 1'b0); lit_b("to_fire1", 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011, 1'b0, 1'b0);
            lit_b($sformatf("to_hold1_%0d", i), 4'b0010, 1'b0);
        end
        cyc(4'b0011, 1'b0, 1'b0); lit_b("to_fire2", 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011, 1'b0, 1'b0);
            lit_b($sformatf("to_hold2_%0d", i), 4'b0001, 1'b0);
        end
        // done coinciding with the limit is a normal release
        cyc(4'b0011, 1'b1, 1'b0); lit_b("to_done", 4'b0010, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0); lit_b("to_idle", 4'b0000, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
